// File: rtl/aes_pkg.sv
// Shared AES types, constants and key slicing helpers.
// Byte 0 of a word and word 0 of a key sit in the most significant bits.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    SUB
  } ks_state_t;

  localparam int         AES128_NR = 10;
  localparam logic [7:0] RCON_LAST = 8'h36;

  // Inverse of xtime in GF(2^8): steps Rcon one round backwards.
  function automatic logic [7:0] inv_xtime(input logic [7:0] b);
    inv_xtime = b[0] ? (((b ^ 8'h1B) >> 1) | 8'h80) : (b >> 1);
  endfunction

  function automatic logic [31:0] key_word(
    input logic [127:0] k,
    input logic [1:0]   i
  );
    key_word = k[{~i, 5'd0} +: 32];
  endfunction

  function automatic logic [7:0] key_byte(
    input logic [31:0] w,
    input logic [1:0]  j
  );
    key_byte = w[{~j, 3'd0} +: 8];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box.
// Also serves the inverse key schedule, which runs SubWord forwards.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/inv_key_schedule.sv
// AES-128 inverse key schedule: emits round keys 10 down to 0.
// AES_INV_KS_SBOX4_EN: four S-boxes, one-cycle SUB state.
module inv_key_schedule #(
  parameter int         NR        = aes_pkg::AES128_NR,
  parameter logic [7:0] RCON_LAST = aes_pkg::RCON_LAST
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] last_key,
  output logic [127:0] rkey,
  output logic [3:0]   rkey_round,
  output logic         rkey_valid,
  input  logic         rkey_ready,
  output logic         busy,
  output logic         done
);

  import aes_pkg::*;

  ks_state_t    state_q, state_d;
  logic [127:0] rkey_q, rkey_d;
  logic [3:0]   round_q, round_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [7:0]   rcon_q, rcon_d;

  logic [31:0]  w3p, w2p, w1p;
  logic [31:0]  sub_word;
  logic [127:0] prev_key;
  logic         sub_last;

  if (NR != AES128_NR) begin : g_bad_nr
    $error("inv_key_schedule supports only NR=10");
  end

  assign w3p = key_word(rkey_q, 2'd3)
             ^ key_word(rkey_q, 2'd2);
  assign w2p = key_word(rkey_q, 2'd2)
             ^ key_word(rkey_q, 2'd1);
  assign w1p = key_word(rkey_q, 2'd1)
             ^ key_word(rkey_q, 2'd0);

  assign prev_key = {
    key_word(rkey_q, 2'd0) ^ sub_word ^ {rcon_q, 24'h0},
    w1p, w2p, w3p
  };

`ifdef AES_INV_KS_SBOX4_EN
  for (genvar k = 0; k < 4; k++) begin : g_sbox
    localparam logic [1:0] SRC = 2'((k + 1) % 4);
    logic [7:0] sb_out;
    aes_sbox u_sbox (
      .in_byte  (key_byte(w3p, SRC)),
      .out_byte (sb_out)
    );
    assign sub_word[31-8*k -: 8] = sb_out;
  end

  assign sub_last = 1'b1;
`else
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] sw_q, sw_d;
  logic [7:0]  sb_in, sb_out;

  // cnt k substitutes byte k+1 of w3', which is RotWord order.
  assign sb_in = key_byte(w3p, cnt_q + 2'd1);

  aes_sbox u_sbox (
    .in_byte  (sb_in),
    .out_byte (sb_out)
  );

  assign sub_word = {sw_q, sb_out};
  assign sub_last = (cnt_q == 2'd3);

  always_comb begin
    cnt_d = cnt_q;
    sw_d  = sw_q;
    if (state_q == SUB) begin
      cnt_d = cnt_q + 2'd1;
      unique case (cnt_q)
        2'd0:    sw_d[23:16] = sb_out;
        2'd1:    sw_d[15:8]  = sb_out;
        2'd2:    sw_d[7:0]   = sb_out;
        default: sw_d        = sw_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sw_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sw_q  <= sw_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    rkey_d  = rkey_q;
    round_d = round_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rcon_d  = rcon_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EMIT;
          rkey_d  = last_key;
          round_d = 4'(NR);
          rcon_d  = RCON_LAST;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      EMIT: begin
        if (rkey_ready) begin
          valid_d = 1'b0;
          if (round_q == 4'd0) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = SUB;
          end
        end
      end
      SUB: begin
        if (sub_last) begin
          state_d = EMIT;
          rkey_d  = prev_key;
          round_d = round_q - 4'd1;
          rcon_d  = inv_xtime(rcon_q);
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rkey_q  <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rcon_q  <= RCON_LAST;
    end else begin
      state_q <= state_d;
      rkey_q  <= rkey_d;
      round_q <= round_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rcon_q  <= rcon_d;
    end
  end

  assign rkey       = rkey_q;
  assign rkey_round = round_q;
  assign rkey_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for inv_key_schedule using the FIPS-197 AES-128 key.
// Define AES_INV_KS_SBOX4_EN to check the one-cycle SUB latency.
module tb_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] last_key;
  logic [127:0] rkey;
  logic [3:0]   rkey_round;
  logic         rkey_valid;
  logic         rkey_ready;
  logic         busy;
  logic         done;

  int n_asserts = 0;
  int n_fail    = 0;
  int xfer_total = 0;
  int xr [0:255];
  int base;
  int w;
  logic [127:0] exp_key [0:10];

`ifdef AES_INV_KS_SBOX4_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 5;
`endif

  always #5 clk = ~clk;

  inv_key_schedule dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .last_key   (last_key),
    .rkey       (rkey),
    .rkey_round (rkey_round),
    .rkey_valid (rkey_valid),
    .rkey_ready (rkey_ready),
    .busy       (busy),
    .done       (done)
  );

  // Record every handshake that the next rising edge will complete.
  always begin
    @(negedge clk);
    #2;
    if (!rst && rkey_valid && rkey_ready) begin
      if (xfer_total < 256) xr[xfer_total] <= int'(rkey_round);
      xfer_total <= xfer_total + 1;
    end
  end

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_key(input int r, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!rkey_valid && waited < 20);
    chk($sformatf("valid_r%0d", r), 128'(rkey_valid), 128'd1);
    chk($sformatf("key_r%0d", r), rkey, exp_key[r]);
    chk($sformatf("round_r%0d", r), 128'(rkey_round), 128'(r));
  endtask

  task automatic walk(input int from, input int to, input bit gap_chk);
    int wt;
    for (int r = from; r >= to; r--) begin
      expect_key(r, wt);
      if (gap_chk)
        chk($sformatf("gap_r%0d", r), 128'(wt), 128'(GAP));
    end
  endtask

  task automatic expect_done();
    @(negedge clk);
    chk("done_hi", 128'(done), 128'd1);
    chk("done_busy", 128'(busy), 128'd0);
    chk("done_valid", 128'(rkey_valid), 128'd0);
    chk("done_round", 128'(rkey_round), 128'd0);
    @(negedge clk);
    chk("done_lo", 128'(done), 128'd0);
  endtask

  task automatic check_seq(input int b);
    chk("xfer_cnt", 128'(xfer_total - b), 128'd11);
    for (int i = 0; i < 11; i++)
      if (b + i < 256)
        chk($sformatf("xfer_%0d", i), 128'(xr[b+i]), 128'(10 - i));
  endtask

  initial begin
    exp_key[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_key[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_key[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_key[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_key[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_key[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_key[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_key[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_key[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_key[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_key[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst        = 1'b1;
    start      = 1'b0;
    rkey_ready = 1'b0;
    last_key   = '0;
    repeat (2) @(negedge clk);
    chk("rst_rkey", rkey, 128'd0);
    chk("rst_round", 128'(rkey_round), 128'd0);
    chk("rst_valid", 128'(rkey_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);

    // Ready without valid must not disturb an idle block.
    rst        = 1'b0;
    rkey_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_valid", 128'(rkey_valid), 128'd0);
    chk("idle_busy", 128'(busy), 128'd0);

    // Known answer walk plus latency.
    base     = xfer_total;
    start    = 1'b1;
    last_key = exp_key[10];
    expect_key(10, w);
    start = 1'b0;
    chk("first_lat", 128'(w), 128'd1);
    chk("busy_emit", 128'(busy), 128'd1);
    walk(9, 0, 1'b1);
    expect_done();
    check_seq(base);

    // Backpressure on round 9.
    base  = xfer_total;
    start = 1'b1;
    expect_key(10, w);
    start = 1'b0;
    @(negedge clk);
    rkey_ready = 1'b0;
    expect_key(9, w);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("bp_valid", 128'(rkey_valid), 128'd1);
      chk("bp_key", rkey, exp_key[9]);
      chk("bp_round", 128'(rkey_round), 128'd9);
    end
    rkey_ready = 1'b1;
    walk(8, 0, 1'b1);
    expect_done();
    check_seq(base);

    // Start while busy is ignored.
    base  = xfer_total;
    start = 1'b1;
    expect_key(10, w);
    start = 1'b0;
    walk(9, 5, 1'b1);
    start    = 1'b1;
    last_key = 128'h00112233445566778899aabbccddeeff;
    @(negedge clk);
    chk("sb_busy", 128'(busy), 128'd1);
    start    = 1'b0;
    last_key = exp_key[10];
    walk(4, 0, 1'b0);
    expect_done();
    check_seq(base);

    // Reset mid-walk at round 4.
    base  = xfer_total;
    start = 1'b1;
    expect_key(10, w);
    start = 1'b0;
    walk(9, 4, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_rkey", rkey, 128'd0);
    chk("mr_round", 128'(rkey_round), 128'd0);
    chk("mr_valid", 128'(rkey_valid), 128'd0);
    chk("mr_busy", 128'(busy), 128'd0);
    chk("mr_done", 128'(done), 128'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mr_no_done", 128'(done), 128'd0);
      chk("mr_idle", 128'(rkey_valid), 128'd0);
    end
    chk("mr_xfers", 128'(xfer_total - base), 128'd6);
    base  = xfer_total;
    start = 1'b1;
    expect_key(10, w);
    start = 1'b0;
    chk("mr_first_lat", 128'(w), 128'd1);
    walk(9, 0, 1'b1);
    expect_done();
    check_seq(base);

    // Back-to-back with start held through done.
    base  = xfer_total;
    start = 1'b1;
    expect_key(10, w);
    walk(9, 0, 1'b1);
    @(negedge clk);
    chk("b2b_done", 128'(done), 128'd1);
    chk("b2b_busy", 128'(busy), 128'd0);
    check_seq(base);
    base = base + 11;
    @(negedge clk);
    chk("b2b_valid", 128'(rkey_valid), 128'd1);
    chk("b2b_round", 128'(rkey_round), 128'd10);
    chk("b2b_key", rkey, exp_key[10]);
    chk("b2b_done_lo", 128'(done), 128'd0);
    start = 1'b0;
    walk(9, 0, 1'b1);
    expect_done();
    check_seq(base);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end

endmodule
